// File: rtl/enemy_fire_scheduler.sv
// rtl/enemy_fire_scheduler.sv - round-robin enemy shot scheduler with tick cooldown and LFSR jitter
module enemy_fire_scheduler #(
  parameter int COOLDOWN_TICKS = 40,
  parameter int JITTER_BITS    = 3,
  parameter int MAX_ATIVAS     = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        tick,
  input  logic        pausa,
  input  logic [4:0]  inimigo_vivo,
  input  logic [4:0]  bola_ativa,
  input  logic        disparo_ack,
  output logic [4:0]  disparo,
  output logic [2:0]  disparo_idx,
  output logic [1:0]  estado,
  output logic [15:0] disparos_total
);

  typedef enum logic [1:0] {
    ST_COOLDOWN = 2'd0,
    ST_SELECT   = 2'd1,
    ST_REQUEST  = 2'd2
  } state_t;

  // Low JITTER_BITS of the LFSR; an all-zero mask when jitter is disabled
  localparam logic [7:0] JITTER_MASK = 8'((1 << JITTER_BITS) - 1);
  localparam logic [7:0] LFSR_SEED   = 8'hA5;

  state_t      r_state;
  logic [7:0]  r_cooldown;
  logic [2:0]  r_rr;
  logic [2:0]  r_tgt;
  logic [15:0] r_total;
  logic [4:0]  r_disparo;
  logic [2:0]  r_idx;
  logic [7:0]  r_lfsr;

  state_t      w_state_nxt;
  logic [7:0]  w_cooldown_nxt;
  logic [2:0]  w_rr_nxt;
  logic [2:0]  w_tgt_nxt;
  logic [15:0] w_total_nxt;
  logic [4:0]  w_disparo_nxt;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  w_lfsr_nxt;
  logic [7:0]  w_reload;
  logic [4:0]  w_cand;
  logic [2:0]  w_busy;
  logic        w_gate;
  logic        w_found;
  logic [2:0]  w_win;
  logic [2:0]  w_pos;

  // Index arithmetic modulo the five enemy slots (input never exceeds 9)
  function automatic logic [2:0] f_wrap5(input logic [3:0] s);
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  // Galois form of x^8+x^6+x^5+x^4+1, shifting towards bit 0
  assign w_lfsr_nxt = r_lfsr[0] ? ({1'b0, r_lfsr[7:1]} ^ 8'hB8) : {1'b0, r_lfsr[7:1]};
  assign w_reload   = 8'(COOLDOWN_TICKS) + (r_lfsr & JITTER_MASK);
  assign w_cand     = inimigo_vivo & ~bola_ativa;
  assign w_gate     = (w_busy < 3'(MAX_ATIVAS));

  // Count bullets in flight for the global gate
  always_comb begin
    w_busy = 3'd0;
    for (int i = 0; i < 5; i++) begin
      w_busy = w_busy + 3'(bola_ativa[i]);
    end
  end

  // Round-robin search from r_rr; scanning backwards lets the nearest candidate win
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    w_pos   = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      w_pos = f_wrap5({1'b0, r_rr} + 4'(k));
      if (w_cand[w_pos]) begin
        w_found = 1'b1;
        w_win   = w_pos;
      end
    end
  end

  // Next-state and registered-output decode; pausa freezes everything and blanks the request
  always_comb begin
    w_state_nxt    = r_state;
    w_cooldown_nxt = r_cooldown;
    w_rr_nxt       = r_rr;
    w_tgt_nxt      = r_tgt;
    w_total_nxt    = r_total;
    if (!pausa) begin
      case (r_state)
        ST_COOLDOWN: begin
          if (r_cooldown == 8'd0) begin
            w_state_nxt = ST_SELECT;
          end else if (tick) begin
            w_cooldown_nxt = r_cooldown - 8'd1;
            if (r_cooldown == 8'd1) begin
              w_state_nxt = ST_SELECT;
            end
          end
        end
        ST_SELECT: begin
          if (w_gate && w_found) begin
            w_tgt_nxt   = w_win;
            w_state_nxt = ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (disparo_ack) begin
            w_total_nxt    = r_total + 16'd1;
            w_rr_nxt       = f_wrap5({1'b0, r_tgt} + 4'd1);
            w_cooldown_nxt = w_reload;
            w_state_nxt    = ST_COOLDOWN;
          end else if (!inimigo_vivo[r_tgt]) begin
            w_state_nxt = ST_SELECT;
          end
        end
        default: begin
          w_state_nxt = ST_COOLDOWN;
        end
      endcase
    end
    w_disparo_nxt = 5'd0;
    w_idx_nxt     = 3'd0;
    if (!pausa && (w_state_nxt == ST_REQUEST)) begin
      w_disparo_nxt = 5'd1 << w_tgt_nxt;
      w_idx_nxt     = w_tgt_nxt;
    end
  end

  // Scheduler state, counters and the registered request outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= ST_COOLDOWN;
      r_cooldown <= 8'(COOLDOWN_TICKS);
      r_rr       <= 3'd0;
      r_tgt      <= 3'd0;
      r_total    <= 16'd0;
      r_disparo  <= 5'd0;
      r_idx      <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cooldown <= w_cooldown_nxt;
      r_rr       <= w_rr_nxt;
      r_tgt      <= w_tgt_nxt;
      r_total    <= w_total_nxt;
      r_disparo  <= w_disparo_nxt;
      r_idx      <= w_idx_nxt;
    end
  end

  // Jitter source runs every cycle out of reset, including while paused
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= w_lfsr_nxt;
    end
  end

  // Largest reload value must fit the 8-bit cooldown counter
  always_ff @(posedge CLOCK_50) begin
    assert (COOLDOWN_TICKS + (1 << JITTER_BITS) - 1 <= 255)
      else $error("cooldown reload does not fit 8 bits");
  end

  assign disparo        = r_disparo;
  assign disparo_idx    = r_idx;
  assign estado         = r_state;
  assign disparos_total = r_total;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// tb/tb_enemy_fire_scheduler.sv - scoreboard bench for enemy_fire_scheduler
module tb_enemy_fire_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_tick, a_pausa, a_ack;
  logic [4:0]  a_vivo, a_bola;
  logic [4:0]  a_disparo;
  logic [2:0]  a_idx;
  logic [1:0]  a_estado;
  logic [15:0] a_total;

  logic        b_reset, b_tick, b_pausa, b_ack;
  logic [4:0]  b_vivo, b_bola;
  logic [4:0]  b_disparo;
  logic [2:0]  b_idx;
  logic [1:0]  b_estado;
  logic [15:0] b_total;

  enemy_fire_scheduler #(.COOLDOWN_TICKS(4), .JITTER_BITS(0), .MAX_ATIVAS(2)) u_a (
    .CLOCK_50(clk), .reset(a_reset), .tick(a_tick), .pausa(a_pausa),
    .inimigo_vivo(a_vivo), .bola_ativa(a_bola), .disparo_ack(a_ack),
    .disparo(a_disparo), .disparo_idx(a_idx), .estado(a_estado), .disparos_total(a_total)
  );

  enemy_fire_scheduler #(.COOLDOWN_TICKS(4), .JITTER_BITS(3), .MAX_ATIVAS(3)) u_b (
    .CLOCK_50(clk), .reset(b_reset), .tick(b_tick), .pausa(b_pausa),
    .inimigo_vivo(b_vivo), .bola_ativa(b_bola), .disparo_ack(b_ack),
    .disparo(b_disparo), .disparo_idx(b_idx), .estado(b_estado), .disparos_total(b_total)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int         rl_q[$];
  logic [4:0] prev_disp;
  logic [7:0] m_lfsr;

  // Reference LFSR for the jitter DUT: seed on reset, x^8+x^6+x^5+x^4+1 otherwise
  always @(posedge clk) begin
    if (b_reset) m_lfsr <= 8'hA5;
    else m_lfsr <= (m_lfsr >> 1) ^ {m_lfsr[0], 1'b0, m_lfsr[0], m_lfsr[0], m_lfsr[0], 3'b000};
  end

  // Monitor: every fresh request from DUT A is matched against the next expected one
  always @(negedge clk) begin
    logic [7:0] e;
    if (a_disparo != 5'd0 && prev_disp == 5'd0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got disparo=%b idx=%0d, expected no request", a_disparo, a_idx);
      end else begin
        e = exp_q.pop_front();
        if (a_disparo !== e[7:3] || a_idx !== e[2:0] || !$onehot(a_disparo)) begin
          n_errors++;
          $display("FAIL sb_request: got disparo=%b idx=%0d, expected disparo=%b idx=%0d",
                   a_disparo, a_idx, e[7:3], e[2:0]);
        end
      end
    end
    prev_disp = a_disparo;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_do_reset();
    a_reset = 1'b1;
    step();
    step();
    a_reset = 1'b0;
  endtask

  task automatic a_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      a_tick = 1'b1;
      step();
      a_tick = 1'b0;
      step();
    end
  endtask

  task automatic a_ack_pulse();
    step();
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
  endtask

  task automatic a_shot(input logic [4:0] d, input logic [2:0] i);
    exp_q.push_back({d, i});
    a_ticks(4);
    check("req_state", a_estado, 2);
    a_ack_pulse();
  endtask

  // Tick DUT B until it leaves COOLDOWN; n is the number of ticks it took, ends in REQUEST
  task automatic b_measure(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      b_tick = 1'b1;
      step();
      b_tick = 1'b0;
      n++;
      if (b_estado == 2'd1) break;
      step();
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e;
    a_reset = 1'b1; a_tick = 1'b0; a_pausa = 1'b0; a_ack = 1'b0;
    a_vivo = 5'b11111; a_bola = 5'b00000;
    b_reset = 1'b1; b_tick = 1'b0; b_pausa = 1'b0; b_ack = 1'b0;
    b_vivo = 5'b11111; b_bola = 5'b00000;

    // Reset state and basic rotation with fixed cooldown of 4 ticks
    a_do_reset();
    check("rst_estado", a_estado, 0);
    check("rst_disparo", a_disparo, 0);
    check("rst_idx", a_idx, 0);
    check("rst_total", a_total, 0);
    exp_q.push_back({5'b00001, 3'd0});
    a_ticks(3);
    check("cd_after3_estado", a_estado, 0);
    check("cd_after3_disparo", a_disparo, 0);
    a_ticks(1);
    check("first_req_estado", a_estado, 2);
    a_ack_pulse();
    a_shot(5'b00010, 3'd1);
    a_shot(5'b00100, 3'd2);
    a_shot(5'b01000, 3'd3);
    a_shot(5'b10000, 3'd4);
    a_shot(5'b00001, 3'd0);
    check("rot_total", a_total, 6);
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
    check("ack_outside_req", a_total, 6);

    // Sparse alive mask: only enemies 2 and 4 may fire
    a_do_reset();
    a_vivo = 5'b10100;
    a_shot(5'b00100, 3'd2);
    a_shot(5'b10000, 3'd4);
    a_shot(5'b00100, 3'd2);
    check("sparse_total", a_total, 3);

    // Global gate: two bullets in flight blocks SELECT until one lands
    a_do_reset();
    a_vivo = 5'b11111;
    a_shot(5'b00001, 3'd0);
    a_shot(5'b00010, 3'd1);
    a_bola = 5'b00011;
    a_ticks(4);
    check("gate_estado", a_estado, 1);
    check("gate_disparo", a_disparo, 0);
    step(); step(); step();
    check("gate_hold_estado", a_estado, 1);
    exp_q.push_back({5'b00100, 3'd2});
    a_bola = 5'b00010;
    step();
    step();
    check("gate_reopen_disparo", a_disparo, 5'b00100);
    check("gate_reopen_idx", a_idx, 2);
    a_ack_pulse();
    a_bola = 5'b00000;
    check("gate_total", a_total, 3);

    // Abort: target dies while requested, search moves on to the next enemy
    exp_q.push_back({5'b01000, 3'd3});
    a_ticks(4);
    check("abort_pre_disparo", a_disparo, 5'b01000);
    exp_q.push_back({5'b10000, 3'd4});
    a_vivo = 5'b10111;
    step();
    check("abort_disparo", a_disparo, 0);
    check("abort_estado", a_estado, 1);
    check("abort_total", a_total, 3);
    step();
    check("abort_next_disparo", a_disparo, 5'b10000);
    a_ack_pulse();
    check("abort_ack_total", a_total, 4);

    // Pause during REQUEST: request blanked, ack ignored, same enemy re-asserted
    a_vivo = 5'b01000;
    exp_q.push_back({5'b01000, 3'd3});
    a_ticks(4);
    check("pause_pre_disparo", a_disparo, 5'b01000);
    a_pausa = 1'b1;
    step();
    check("pause_disparo", a_disparo, 0);
    check("pause_idx", a_idx, 0);
    for (int i = 0; i < 9; i++) begin
      a_ack = (i == 3 || i == 6);
      step();
    end
    a_ack = 1'b0;
    check("pause_total", a_total, 4);
    check("pause_estado", a_estado, 2);
    exp_q.push_back({5'b01000, 3'd3});
    a_pausa = 1'b0;
    step();
    check("resume_disparo", a_disparo, 5'b01000);
    a_ack_pulse();
    check("resume_total", a_total, 5);

    // Jitter DUT: reload after each acked shot is 4 + lfsr[2:0] from the seeded reference
    b_reset = 1'b1;
    step();
    step();
    b_reset = 1'b0;
    b_measure(n);
    check("b_first_cd", n, 4);
    for (int s = 0; s < 20; s++) begin
      check("b_req_estado", b_estado, 2);
      rl_q.push_back(4 + int'(m_lfsr[2:0]));
      b_ack = 1'b1;
      step();
      b_ack = 1'b0;
      b_measure(n);
      e = rl_q.pop_front();
      check("b_reload", n, e);
      check("b_reload_range", (n >= 4 && n <= 11), 1);
    end
    check("b_total", b_total, 20);
    b_reset = 1'b1;
    step();
    check("b_midreq_rst_disparo", b_disparo, 0);
    check("b_midreq_rst_estado", b_estado, 0);
    b_reset = 1'b0;
    step();

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
